// File: rtl/uart_ifmap_loader_pkg.sv
// uart_ifmap_loader_pkg
// Shared types and defaults for the UART ifmap loader slice:
//   - RX and loader FSM state enums
//   - default CLKS_PER_BIT, FRAME_LEN and SYNC_BYTE
//   - countWidth(): width of a counter that holds 0..n-1
// The optional macro UART_PARITY_EN only changes behaviour inside uart_rx_core.
// RX_PARITY is always declared so the enum encoding is the same in both builds.
package uart_ifmap_loader_pkg;

  localparam int         DEFAULT_CLKS_PER_BIT = 868;
  localparam int         DEFAULT_FRAME_LEN    = 784;
  localparam logic [7:0] DEFAULT_SYNC_BYTE    = 8'hA5;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } RxState;

  typedef enum logic [1:0] {
    LD_WAIT_SYNC,
    LD_LOAD,
    LD_PAD
  } LoaderState;

  // Width needed to hold 0..n-1; never narrower than one bit.
  function automatic int countWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
// Synchronizes the raw serial line and decodes UART bytes.
// The default format is 8N1. When UART_PARITY_EN is defined, the format is 8E1.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset
//   uart_rx    in   asynchronous serial line, idle high
//   byte_valid out  one-cycle pulse, rx_byte holds a good byte
//   byte_err   out  one-cycle pulse on a framing error (or a parity error)
//   rx_byte    out  last received byte, LSB first on the wire
module uart_rx_core
  import uart_ifmap_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic       byte_err,
  output logic [7:0] rx_byte
);

  localparam int              ClkW    = countWidth(CLKS_PER_BIT);
  localparam logic [ClkW-1:0] HalfBit = ClkW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [ClkW-1:0] FullBit = ClkW'(CLKS_PER_BIT - 1);

  logic            r_syncMeta;
  logic            r_syncRx;
  logic            r_rxPrev;
  RxState          r_state;
  logic [ClkW-1:0] r_clkCount;
  logic [2:0]      r_bitIdx;
  logic [7:0]      r_shift;
  logic            r_waitHigh;
  logic            w_parityErr;

`ifdef UART_PARITY_EN
  logic r_parityErr;
  assign w_parityErr = r_parityErr;
`else
  assign w_parityErr = 1'b0;
`endif

  assign rx_byte = r_shift;

  // Synchronizer, edge history and RX FSM. All decoding uses r_syncRx.
  // After a low stop bit, r_waitHigh holds the FSM in STOP until the line
  // is idle again. This keeps a stuck-low line from being read as a string
  // of start bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_syncMeta  <= 1'b1;
      r_syncRx    <= 1'b1;
      r_rxPrev    <= 1'b1;
      r_state     <= RX_IDLE;
      r_clkCount  <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_waitHigh  <= 1'b0;
      byte_valid  <= 1'b0;
      byte_err    <= 1'b0;
`ifdef UART_PARITY_EN
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_syncMeta <= uart_rx;
      r_syncRx   <= r_syncMeta;
      r_rxPrev   <= r_syncRx;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_rxPrev && !r_syncRx) begin
            r_state    <= RX_START;
            r_clkCount <= '0;
            r_bitIdx   <= '0;
          end
        end
        RX_START: begin
          // Mid-start-bit check: a line that is high again was a glitch.
          if (r_clkCount == HalfBit) begin
            r_clkCount <= '0;
            r_state    <= r_syncRx ? RX_IDLE : RX_DATA;
          end else begin
            r_clkCount <= r_clkCount + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clkCount == FullBit) begin
            r_clkCount <= '0;
            r_shift    <= {r_syncRx, r_shift[7:1]};
            r_bitIdx   <= r_bitIdx + 1'b1;
            if (r_bitIdx == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= RX_PARITY;
`else
              r_state <= RX_STOP;
`endif
            end
          end else begin
            r_clkCount <= r_clkCount + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          // Even parity: the parity bit equals the XOR of the data bits.
          if (r_clkCount == FullBit) begin
            r_clkCount  <= '0;
            r_parityErr <= (r_syncRx != (^r_shift));
            r_state     <= RX_STOP;
          end else begin
            r_clkCount <= r_clkCount + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (r_waitHigh) begin
            if (r_syncRx) begin
              r_waitHigh <= 1'b0;
              r_state    <= RX_IDLE;
            end
          end else if (r_clkCount == FullBit) begin
            r_clkCount <= '0;
            if (!r_syncRx) begin
              byte_err   <= 1'b1;
              r_waitHigh <= 1'b1;
            end else if (w_parityErr) begin
              byte_err <= 1'b1;
              r_state  <= RX_IDLE;
            end else begin
              byte_valid <= 1'b1;
              r_state    <= RX_IDLE;
            end
          end else begin
            r_clkCount <= r_clkCount + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_ifmap_loader.sv
// uart_ifmap_loader
// Receives a UART byte stream and waits for SYNC_BYTE. It then writes exactly
// FRAME_LEN pixels to the ifmap BRAM write port. If a frame is aborted by a
// receive error, the rest of the frame is padded with zeros. This keeps the
// downstream write-address counter frame-aligned.
// Optional macro: UART_PARITY_EN selects 8E1 framing in uart_rx_core.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset
//   uart_rx    in   asynchronous serial line, idle high
//   ifmap_wr   out  one-cycle BRAM write strobe
//   ifmap_data out  pixel byte, valid with ifmap_wr
//   frame_done out  pulse coincident with the FRAME_LEN-th write
//   busy       out  high from sync accepted until frame_done
//   error_flag out  sticky receive-error flag, cleared by the next sync
module uart_ifmap_loader
  import uart_ifmap_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int         FRAME_LEN    = DEFAULT_FRAME_LEN,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       ifmap_wr,
  output logic [7:0] ifmap_data,
  output logic       frame_done,
  output logic       busy,
  output logic       error_flag
);

  localparam int                CountW    = countWidth(FRAME_LEN);
  localparam logic [CountW-1:0] LastPixel = CountW'(FRAME_LEN - 1);

  logic              w_byteValid;
  logic              w_byteErr;
  logic [7:0]        w_rxByte;
  LoaderState        r_state;
  logic [CountW-1:0] r_pixelCount;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rxCore (
    .clock     (clock),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .byte_valid(w_byteValid),
    .byte_err  (w_byteErr),
    .rx_byte   (w_rxByte)
  );

  // Loader FSM. r_pixelCount is the number of writes already issued in the
  // current frame. It never exceeds LastPixel, because the write that
  // reaches FRAME_LEN also returns the FSM to WAIT_SYNC.
  // busy falls one cycle after frame_done, on the first WAIT_SYNC cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= LD_WAIT_SYNC;
      r_pixelCount <= '0;
      ifmap_wr     <= 1'b0;
      ifmap_data   <= '0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      error_flag   <= 1'b0;
    end else begin
      ifmap_wr   <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        LD_WAIT_SYNC: begin
          busy <= 1'b0;
          if (w_byteValid && (w_rxByte == SYNC_BYTE)) begin
            r_state      <= LD_LOAD;
            r_pixelCount <= '0;
            busy         <= 1'b1;
            error_flag   <= 1'b0;
          end
        end
        LD_LOAD: begin
          // A SYNC_BYTE value here is ordinary pixel data.
          if (w_byteValid) begin
            ifmap_wr   <= 1'b1;
            ifmap_data <= w_rxByte;
            if (r_pixelCount == LastPixel) begin
              frame_done   <= 1'b1;
              r_pixelCount <= '0;
              r_state      <= LD_WAIT_SYNC;
            end else begin
              r_pixelCount <= r_pixelCount + 1'b1;
            end
          end else if (w_byteErr) begin
            error_flag <= 1'b1;
            r_state    <= LD_PAD;
          end
        end
        LD_PAD: begin
          // One zero write per cycle until the frame is full. Bytes that
          // arrive meanwhile are ignored.
          ifmap_wr   <= 1'b1;
          ifmap_data <= '0;
          if (r_pixelCount == LastPixel) begin
            frame_done   <= 1'b1;
            r_pixelCount <= '0;
            r_state      <= LD_WAIT_SYNC;
          end else begin
            r_pixelCount <= r_pixelCount + 1'b1;
          end
        end
        default: r_state <= LD_WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ifmap_loader.sv
// tb_uart_ifmap_loader
// Directed bench for uart_ifmap_loader with CLKS_PER_BIT=16. A short frame
// keeps every scenario to a few thousand cycles. With UART_PARITY_EN defined,
// the bench sends 8E1 frames, uses FRAME_LEN=8, and adds the bad-parity
// scenario.
module tb_uart_ifmap_loader;

  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int FL = 8;
`else
  localparam int FL = 20;
`endif
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic       ifmap_wr;
  logic [7:0] ifmap_data;
  logic       frame_done;
  logic       busy;
  logic       error_flag;

  int checks = 0;
  int errors = 0;

  logic [7:0] wrData[$];
  logic       wrDone[$];
  int         wrCycle[$];
  int         doneNoWr = 0;
  int         cycle = 0;
  logic [7:0] expData[FL];

  uart_ifmap_loader #(
    .CLKS_PER_BIT(CPB),
    .FRAME_LEN   (FL),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .ifmap_wr  (ifmap_wr),
    .ifmap_data(ifmap_data),
    .frame_done(frame_done),
    .busy      (busy),
    .error_flag(error_flag)
  );

  always #5 clock = ~clock;

  // Write monitor: logs every strobe at the falling edge, away from updates.
  always @(negedge clock) begin
    cycle++;
    if (ifmap_wr) begin
      wrData.push_back(ifmap_data);
      wrDone.push_back(frame_done);
      wrCycle.push_back(cycle);
    end else if (frame_done) begin
      doneNoWr++;
    end
  end

  task automatic clearLog();
    wrData.delete();
    wrDone.delete();
    wrCycle.delete();
  endtask

  // Sends one UART byte, LSB first. A low stop bit is followed by one idle bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic parityOk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
`ifdef UART_PARITY_EN
    uart_rx = (^b) ^ ~parityOk;
    repeat (CPB) @(negedge clock);
`else
    if (!parityOk) $display("[TB] note: parity request ignored in 8N1 build");
`endif
    uart_rx = stopBit;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
    if (!stopBit) repeat (CPB) @(negedge clock);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clock);
    checks += 5;
    if (ifmap_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr: got %b expected 0", ifmap_wr); end
    if (ifmap_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", ifmap_data); end
    if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", frame_done); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (error_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", error_flag); end
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_frame();
    clearLog();
    applyStimulus(SYNC, 1'b1, 1'b1);
    repeat (4) @(negedge clock);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL frame_busy_after_sync: got %b expected 1", busy); end
    if (wrData.size() != 0) begin errors++; $display("[TB] FAIL frame_sync_written: got %0d writes expected 0", wrData.size()); end
    for (int i = 0; i < FL; i++) begin
      expData[i] = 8'(i);
      applyStimulus(expData[i], 1'b1, 1'b1);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (wrData.size() != FL) begin errors++; $display("[TB] FAIL frame_count: got %0d writes expected %0d", wrData.size(), FL); end
    for (int k = 0; k < FL && k < wrData.size(); k++) begin
      checks++;
      if (wrData[k] !== expData[k] || wrDone[k] !== (k == FL - 1)) begin
        errors++;
        $display("[TB] FAIL frame_write[%0d]: got %h/%b expected %h/%b", k, wrData[k], wrDone[k], expData[k], k == FL - 1);
      end
    end
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL frame_busy_end: got %b expected 0", busy); end
    if (error_flag !== 1'b0) begin errors++; $display("[TB] FAIL frame_err: got %b expected 0", error_flag); end
  endtask

  task automatic test_presync();
    clearLog();
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(8'h12, 1'b1, 1'b1);
    repeat (4) @(negedge clock);
    checks += 2;
    if (wrData.size() != 0) begin errors++; $display("[TB] FAIL presync_writes: got %0d expected 0", wrData.size()); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL presync_busy: got %b expected 0", busy); end
    applyStimulus(SYNC, 1'b1, 1'b1);
    for (int i = 0; i < FL; i++) begin
      expData[i] = (i == 2) ? SYNC : 8'(8'h40 + i);
      applyStimulus(expData[i], 1'b1, 1'b1);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (wrData.size() != FL) begin errors++; $display("[TB] FAIL presync_count: got %0d expected %0d", wrData.size(), FL); end
    for (int k = 0; k < FL && k < wrData.size(); k++) begin
      checks++;
      if (wrData[k] !== expData[k] || wrDone[k] !== (k == FL - 1)) begin
        errors++;
        $display("[TB] FAIL presync_write[%0d]: got %h/%b expected %h/%b", k, wrData[k], wrDone[k], expData[k], k == FL - 1);
      end
    end
  endtask

  task automatic test_glitch();
    clearLog();
    applyStimulus(SYNC, 1'b1, 1'b1);
    uart_rx = 1'b0;
    repeat (3) @(negedge clock);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    checks += 3;
    if (wrData.size() != 0) begin errors++; $display("[TB] FAIL glitch_writes: got %0d expected 0", wrData.size()); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy: got %b expected 1", busy); end
    if (error_flag !== 1'b0) begin errors++; $display("[TB] FAIL glitch_err: got %b expected 0", error_flag); end
    for (int i = 0; i < FL; i++) begin
      expData[i] = 8'(FL - i);
      applyStimulus(expData[i], 1'b1, 1'b1);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (wrData.size() != FL) begin errors++; $display("[TB] FAIL glitch_count: got %0d expected %0d", wrData.size(), FL); end
    for (int k = 0; k < FL && k < wrData.size(); k++) begin
      checks++;
      if (wrData[k] !== expData[k] || wrDone[k] !== (k == FL - 1)) begin
        errors++;
        $display("[TB] FAIL glitch_write[%0d]: got %h/%b expected %h/%b", k, wrData[k], wrDone[k], expData[k], k == FL - 1);
      end
    end
  endtask

  task automatic test_abort();
    int good;
    int gaps;
    good = FL / 2;
    gaps = 0;
    clearLog();
    applyStimulus(SYNC, 1'b1, 1'b1);
    for (int i = 0; i < FL; i++) expData[i] = (i < good) ? 8'(8'h80 + i) : 8'h00;
    for (int i = 0; i < good; i++) applyStimulus(expData[i], 1'b1, 1'b1);
    applyStimulus(8'h5A, 1'b0, 1'b1);
    repeat (FL + 8) @(negedge clock);
    checks++;
    if (wrData.size() != FL) begin errors++; $display("[TB] FAIL abort_count: got %0d expected %0d", wrData.size(), FL); end
    for (int k = 0; k < FL && k < wrData.size(); k++) begin
      checks++;
      if (wrData[k] !== expData[k] || wrDone[k] !== (k == FL - 1)) begin
        errors++;
        $display("[TB] FAIL abort_write[%0d]: got %h/%b expected %h/%b", k, wrData[k], wrDone[k], expData[k], k == FL - 1);
      end
      if (k > good && wrCycle[k] != wrCycle[k - 1] + 1) gaps++;
    end
    checks += 3;
    if (gaps != 0) begin errors++; $display("[TB] FAIL abort_pad_gaps: got %0d gaps expected 0", gaps); end
    if (error_flag !== 1'b1) begin errors++; $display("[TB] FAIL abort_err: got %b expected 1", error_flag); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    clearLog();
    applyStimulus(8'h33, 1'b1, 1'b1);
    repeat (4) @(negedge clock);
    checks += 2;
    if (error_flag !== 1'b1) begin errors++; $display("[TB] FAIL abort_err_sticky: got %b expected 1", error_flag); end
    if (wrData.size() != 0) begin errors++; $display("[TB] FAIL abort_idle_writes: got %0d expected 0", wrData.size()); end
    applyStimulus(SYNC, 1'b1, 1'b1);
    repeat (4) @(negedge clock);
    checks += 2;
    if (error_flag !== 1'b0) begin errors++; $display("[TB] FAIL abort_err_clear: got %b expected 0", error_flag); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_resync_busy: got %b expected 1", busy); end
    for (int i = 0; i < FL; i++) applyStimulus(8'(8'hC0 + i), 1'b1, 1'b1);
    repeat (4) @(negedge clock);
    checks++;
    if (wrData.size() != FL || wrDone[wrDone.size() - 1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_next_frame: got %0d writes expected %0d ending in frame_done", wrData.size(), FL);
    end
  endtask

  task automatic test_midframe_reset();
    int part;
    part = FL / 3;
    clearLog();
    applyStimulus(SYNC, 1'b1, 1'b1);
    for (int i = 0; i < part; i++) applyStimulus(8'(8'h10 + i), 1'b1, 1'b1);
    repeat (4) @(negedge clock);
    checks++;
    if (wrData.size() != part) begin errors++; $display("[TB] FAIL rst_partial: got %0d expected %0d", wrData.size(), part); end
    reset = 1'b1;
    @(negedge clock);
    checks += 4;
    if (ifmap_wr !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr: got %b expected 0", ifmap_wr); end
    if (ifmap_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_data: got %h expected 00", ifmap_data); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    if (frame_done !== 1'b0 || error_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_done_err: got %b/%b expected 0/0", frame_done, error_flag);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clock);
    checks++;
    if (wrData.size() != part) begin errors++; $display("[TB] FAIL rst_no_pad: got %0d expected %0d", wrData.size(), part); end
    clearLog();
    applyStimulus(SYNC, 1'b1, 1'b1);
    for (int i = 0; i < FL; i++) begin
      expData[i] = 8'(3 * i + 1);
      applyStimulus(expData[i], 1'b1, 1'b1);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (wrData.size() != FL) begin errors++; $display("[TB] FAIL rst_frame_count: got %0d expected %0d", wrData.size(), FL); end
    for (int k = 0; k < FL && k < wrData.size(); k++) begin
      checks++;
      if (wrData[k] !== expData[k] || wrDone[k] !== (k == FL - 1)) begin
        errors++;
        $display("[TB] FAIL rst_write[%0d]: got %h/%b expected %h/%b", k, wrData[k], wrDone[k], expData[k], k == FL - 1);
      end
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    clearLog();
    applyStimulus(SYNC, 1'b1, 1'b1);
    for (int i = 0; i < FL; i++) expData[i] = 8'h00;
    expData[0] = 8'h11;
    expData[1] = 8'h22;
    applyStimulus(8'h11, 1'b1, 1'b1);
    applyStimulus(8'h22, 1'b1, 1'b1);
    applyStimulus(8'h33, 1'b1, 1'b0);
    repeat (FL + 3 * CPB) @(negedge clock);
    checks++;
    if (wrData.size() != FL) begin errors++; $display("[TB] FAIL parity_count: got %0d expected %0d", wrData.size(), FL); end
    for (int k = 0; k < FL && k < wrData.size(); k++) begin
      checks++;
      if (wrData[k] !== expData[k] || wrDone[k] !== (k == FL - 1)) begin
        errors++;
        $display("[TB] FAIL parity_write[%0d]: got %h/%b expected %h/%b", k, wrData[k], wrDone[k], expData[k], k == FL - 1);
      end
    end
    checks += 2;
    if (error_flag !== 1'b1) begin errors++; $display("[TB] FAIL parity_err: got %b expected 1", error_flag); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL parity_busy: got %b expected 0", busy); end
  endtask
`endif

  initial begin
    $display("[TB] start, FRAME_LEN=%0d CLKS_PER_BIT=%0d", FL, CPB);
    test_reset();
    test_frame();
    test_presync();
    test_glitch();
    test_abort();
    test_midframe_reset();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    checks++;
    if (doneNoWr != 0) begin errors++; $display("[TB] FAIL done_without_write: got %0d expected 0", doneNoWr); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
